// File: rtl/tt_io_pattern_gen_pkg.sv
// Shared types and constants for the tile digital-pin pattern generator.
package tt_io_pkg;

  typedef enum logic [2:0] {
    MODE_OFF    = 3'd0,
    MODE_STATIC = 3'd1,
    MODE_COUNT  = 3'd2,
    MODE_WALK   = 3'd3,
    MODE_LFSR   = 3'd4,
    MODE_LOOP   = 3'd5
  } mode_e;

  localparam logic [7:0] OP_MODE   = 8'h01;
  localparam logic [7:0] OP_DIV    = 8'h02;
  localparam logic [7:0] OP_OE     = 8'h03;
  localparam logic [7:0] OP_STATIC = 8'h04;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ARG   = 2'd1;
  localparam logic [1:0] ST_APPLY = 2'd2;

  // Taps for x^8+x^6+x^5+x^4+1 expressed on bits 7,5,4,3 of the shift register.
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] p);
    return {p[6:0], ^(p & LFSR_TAPS)};
  endfunction

  function automatic logic is_known_op(input logic [7:0] op);
    return (op >= OP_MODE) && (op <= OP_STATIC);
  endfunction

endpackage

// File: rtl/tt_io_pattern_gen_if.sv
// Byte-wide command port with valid/ready handshake.
interface tt_io_pattern_gen_if;
  logic [7:0] cfg_data;
  logic       cfg_valid;
  logic       cfg_ready;

  modport master (output cfg_data, output cfg_valid, input cfg_ready);
  modport slave  (input cfg_data, input cfg_valid, output cfg_ready);
endinterface

// File: rtl/tt_io_pattern_gen_prescaler.sv
// Tick prescaler: counts 0..div and pulses tick in the cycle after the terminal count.
module tt_io_prescaler #(
  parameter int DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [DIV_W-1:0] div,
  output logic             adv,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_reg;
  logic             tick_reg;
  logic             at_tc;

  assign at_tc = en && (cnt_reg == div);
  // A clear wins over a coincident terminal count, so no advance is lost or doubled.
  assign adv   = at_tc && !clr;
  assign tick  = tick_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (clr) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b0;
    end else if (at_tc) begin
      cnt_reg  <= '0;
      tick_reg <= 1'b1;
    end else begin
      tick_reg <= 1'b0;
      if (en) begin
        cnt_reg <= cnt_reg + DIV_W'(1);
      end
    end
  end

endmodule

// File: rtl/tt_io_pattern_gen.sv
// Digital pin drive stage: command-configured test patterns on uo_out/uio_out/uio_oe.
module tt_io_pattern_gen
  import tt_io_pkg::*;
#(
  parameter int         DIV_W     = 8,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ena,
  tt_io_pattern_gen_if.slave  cfg,
  input  logic [7:0]          loop_in,
  output logic [7:0]          uo_out,
  output logic [7:0]          uio_out,
  output logic [7:0]          uio_oe,
  output logic                tick,
  output logic                err
);

  logic [1:0]       state_reg;
  logic [7:0]       op_reg;
  logic [7:0]       arg_reg;
  logic             err_reg;
  logic             xfer;
  logic             apply;

  logic [2:0]       mode_reg;
  logic [DIV_W-1:0] div_reg;
  logic [7:0]       oe_reg;
  logic [7:0]       static_reg;
  logic [7:0]       pat_reg;
  logic [7:0]       loop_reg;
  logic [7:0]       pattern;
  logic [7:0]       uo_reg;
  logic [7:0]       oe_out_reg;

  logic             presc_clr;
  logic             adv;

  assign cfg.cfg_ready = (state_reg != ST_APPLY);
  assign xfer          = cfg.cfg_valid && cfg.cfg_ready;
  assign apply         = (state_reg == ST_APPLY);
  assign err           = err_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      op_reg    <= 8'h00;
      arg_reg   <= 8'h00;
      err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (xfer) begin
            if (is_known_op(cfg.cfg_data)) begin
              op_reg    <= cfg.cfg_data;
              state_reg <= ST_ARG;
            end else begin
              err_reg <= 1'b1;
            end
          end
        end
        ST_ARG: begin
          if (xfer) begin
            arg_reg   <= cfg.cfg_data;
            state_reg <= ST_APPLY;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg   <= MODE_OFF;
      div_reg    <= '1;
      oe_reg     <= 8'h00;
      static_reg <= 8'h00;
    end else if (apply) begin
      case (op_reg)
        OP_MODE:   mode_reg   <= arg_reg[2:0];
        OP_DIV:    div_reg    <= DIV_W'(arg_reg);
        OP_OE:     oe_reg     <= arg_reg;
        OP_STATIC: static_reg <= arg_reg;
        default:   ;
      endcase
    end
  end

  assign presc_clr = apply && ((op_reg == OP_MODE) || (op_reg == OP_DIV));

  tt_io_prescaler #(.DIV_W(DIV_W)) u_prescaler (
    .clk  (clk),
    .rst  (rst),
    .en   (ena),
    .clr  (presc_clr),
    .div  (div_reg),
    .adv  (adv),
    .tick (tick)
  );

  // Mode entry reloads the sequence state even when the same mode is reapplied.
  always_ff @(posedge clk) begin
    if (rst) begin
      pat_reg <= 8'h00;
    end else if (apply && (op_reg == OP_MODE)) begin
      case (arg_reg[2:0])
        MODE_COUNT: pat_reg <= 8'h00;
        MODE_WALK:  pat_reg <= 8'h01;
        MODE_LFSR:  pat_reg <= LFSR_SEED;
        default:    pat_reg <= 8'h00;
      endcase
    end else if (adv) begin
      case (mode_reg)
        MODE_COUNT: pat_reg <= pat_reg + 8'h01;
        MODE_WALK:  pat_reg <= {pat_reg[6:0], pat_reg[7]};
        MODE_LFSR:  pat_reg <= lfsr_next(pat_reg);
        default:    pat_reg <= pat_reg;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      loop_reg <= 8'h00;
    end else if (ena) begin
      loop_reg <= loop_in;
    end
  end

  always_comb begin
    pattern = 8'h00;
    case (mode_reg)
      MODE_STATIC:                      pattern = static_reg;
      MODE_COUNT, MODE_WALK, MODE_LFSR: pattern = pat_reg;
      MODE_LOOP:                        pattern = loop_reg;
      default:                          pattern = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      uo_reg     <= 8'h00;
      oe_out_reg <= 8'h00;
    end else begin
      uo_reg     <= pattern;
      oe_out_reg <= oe_reg;
    end
  end

  assign uo_out = uo_reg;
  assign uio_oe = oe_out_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_uio
      logic inv_reg;
      always_ff @(posedge clk) begin
        if (rst) begin
          inv_reg <= 1'b1;
        end else begin
          inv_reg <= ~pattern[gi];
        end
      end
      assign uio_out[gi] = inv_reg;
    end
  endgenerate

endmodule
